// File: rtl/bcd_pkg.sv
// Shared defaults, FSM encoding and BCD range helpers for the BCD converter arbiter.
package bcd_pkg;

  localparam int unsigned BinWDefault   = 20;
  localparam int unsigned DigitsDefault = 6;

  // Largest value representable in DigitsDefault BCD digits.
  localparam logic [63:0] BcdLimitDefault = 64'd999999;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } bcd_state_e;

  // 10^digits - 1 for an arbitrary digit count (valid up to 19 digits).
  function automatic logic [63:0] bcd_limit(input int unsigned digits);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in one operand bit.
module bcd_dabble_step #(
  parameter int unsigned DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] acc,
  input  logic                shift_bit,
  output logic [4*DIGITS-1:0] next_acc
);

  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    next_acc = {adj[4*DIGITS-2:0], shift_bit};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shared binary-to-BCD converter serving N_REQ requesters through a one-hot grant.
// Define BCD_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned BIN_W  = BinWDefault,
  parameter int unsigned DIGITS = DigitsDefault
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BIN_W-1:0]     req_bin,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [4*DIGITS-1:0]        rsp_bcd,
  output logic                       rsp_ovf,
  output logic                       busy
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [63:0]     Limit    = bcd_limit(DIGITS);
  localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};

  bcd_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [BcdW-1:0] acc_q;
  logic [BcdW-1:0] next_acc;
  logic [BIN_W-1:0] operand_q;
  logic            op_ovf_q;
  logic [IdW-1:0]  id_q;
  logic [BcdW-1:0] bcd_q;
  logic            valid_q;
  logic            rsp_ovf_q;
  logic            busy_q;

  logic [N_REQ-1:0] grant;
  logic [IdW-1:0]   grant_idx;
  logic             grant_any;
  logic [BIN_W-1:0] sel_bin;
  logic             sel_ovf;

`ifdef BCD_ARB_ROUND_ROBIN_EN
  logic [IdW-1:0] last_q;

  // Search begins just after the most recently granted requester.
  always_comb begin
    logic [IdW-1:0] idx;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IdW'((32'(last_q) + k) % N_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IdW'(N_REQ - 1);
    end else if (state_q == StIdle && grant_any) begin
      last_q <= grant_idx;
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    grant_any = |req_valid;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        grant_idx = IdW'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    req_ready = (state_q == StIdle) ? grant : '0;
    sel_bin   = req_bin[32'(grant_idx) * BIN_W +: BIN_W];
    sel_ovf   = 64'(sel_bin) > Limit;
  end

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .acc       (acc_q),
    .shift_bit (operand_q[BIN_W-1]),
    .next_acc  (next_acc)
  );

  // Shifts run for cnt 0..BIN_W-1; the cycle at cnt == BIN_W registers the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      op_ovf_q  <= 1'b0;
      id_q      <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      rsp_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            operand_q <= sel_bin;
            op_ovf_q  <= sel_ovf;
            id_q      <= grant_idx;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (cnt_q == CntW'(BIN_W)) begin
            bcd_q     <= op_ovf_q ? AllNines : acc_q;
            rsp_ovf_q <= op_ovf_q;
            valid_q   <= 1'b1;
            state_q   <= StDone;
          end else begin
            acc_q     <= next_acc;
            operand_q <= operand_q << 1;
            cnt_q     <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (rsp_ready) begin
            bcd_q     <= '0;
            rsp_ovf_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_bcd   = bcd_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign busy      = busy_q;

endmodule
